// File: rtl/corescore_collector_uart.sv
// rtl/corescore_collector_uart.sv - 8N1 UART receiver producing a valid/ready byte stream
// Mid-bit sampling, with frame error and overrun pulses reported beside the data.
module corescore_collector_uart #(
    parameter int clk_freq_hz = 27000000,
    parameter int baud_rate   = 115200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int BIT  = clk_freq_hz / baud_rate;
    localparam int HALF = BIT / 2;
    localparam int TW   = $clog2(BIT) + 1;

    localparam logic [TW-1:0] BIT_RELOAD  = TW'(BIT - 1);
    localparam logic [TW-1:0] HALF_RELOAD = TW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [TW-1:0] timer;
    logic [2:0]    index;
    logic [7:0]    shreg;

    logic sample;
    logic byte_done;

    assign sample    = (timer == '0);
    assign byte_done = (state == STOP) && sample && rx_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            timer       <= '0;
            index       <= '0;
            shreg       <= '0;
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            rx_meta     <= i_uart_rx;
            rx_s        <= rx_meta;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;

            // A completing byte may replace one being accepted in the same cycle.
            if (byte_done) begin
                if (!o_valid || i_ready) begin
                    o_data  <= shreg;
                    o_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        timer <= HALF_RELOAD;
                    end
                end
                START: begin
                    if (sample) begin
                        if (!rx_s) begin
                            state <= DATA;
                            timer <= BIT_RELOAD;
                            index <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shreg <= {rx_s, shreg[7:1]};
                        timer <= BIT_RELOAD;
                        index <= index + 1'b1;
                        if (index == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                STOP: begin
                    if (sample) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // A held-low break yields one frame error, not one per bit time.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
